despread: RTL
=============

Name: despread

Overview:
- Receive-side counterpart of the spectrum spreader: accepts the chip stream produced by spreading (chip = code[k] XOR data bit) and recovers one information bit per SPREAD chips.
- Regenerates the same SPREAD-chip code via the shared lfsr primitive after reset, XORs each incoming chip with the code, counts ones over the symbol and makes a majority decision.
- Sits between the chip source (channel/demodulator output) and the bit sink; reports a per-symbol agreement count for link-quality monitoring.

Parameters:
- SPREAD, 24, chips per information bit (code length); must be >= 3.
- SIZE_COUNTER, $clog2(SPREAD), width of the chip index counter.
- CORR_W, $clog2(SPREAD+1), width of the ones-count accumulator and o_corr.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_data  in  1  received chip
- i_valid  in  1  i_data valid this cycle
- i_sync  in  1  qualified by i_valid: this chip is chip index 0 of a new symbol
- o_ready  out  1  high once the code is loaded; chips are accepted only while high
- o_data  out  1  recovered information bit
- o_valid  out  1  one-cycle strobe, o_data/o_corr/o_tie valid
- o_corr  out  CORR_W  number of chips in the symbol whose XOR with the code was 1
- o_tie  out  1  o_corr == SPREAD/2 exactly (even SPREAD only); decision forced to 0

Behaviour:
- Reset values: o_ready=0, o_valid=0, o_data=0, o_corr=0, o_tie=0; code register, chip index and accumulator = 0; FSM = LOAD.
- LOAD: lfsr i_valid driven 1 from reset release. Each cycle code[load_cnt] <= lfsr o_data, load_cnt++. When load_cnt == SPREAD-1, drop lfsr i_valid and go to RUN. The code must be bit-identical to the spreader's code (same lfsr, same capture order, bit 0 first).
- RUN: o_ready is registered and rises the cycle after LOAD exits, then stays 1 until reset. Chips presented while o_ready=0 are ignored.
- Per accepted chip (i_valid & o_ready):
  - x = i_data ^ code[idx], where idx = 0 if i_sync, else the chip index.
  - If idx < SPREAD-1: acc <= acc + x (with acc = 0 first when i_sync); idx <= idx+1.
  - If idx == SPREAD-1: total = acc + x. Next cycle o_valid=1, o_corr=total, o_data = (total > SPREAD/2), o_tie = (total*2 == SPREAD). acc <= 0, idx <= 0.
- Latency: o_valid is asserted exactly 1 cycle after the last chip of a symbol is accepted. Back-to-back symbols run with no bubble; a chip accepted in the o_valid cycle counts toward the next symbol.
- i_valid=0: idx and acc hold. Gaps of any length within a symbol are allowed.
- o_valid is high for 1 cycle per symbol. o_data, o_corr and o_tie hold their last values while o_valid=0.
- i_sync mid-symbol: the partial accumulation is discarded with no o_valid, and this chip is index 0 of the new symbol. i_sync on the expected index-0 chip has no side effect. i_sync without i_valid is ignored.
- Arithmetic: acc never exceeds SPREAD, so no saturation logic is needed.
- Reset mid-operation: all state returns to reset values, the code reload restarts, and any partial symbol is lost. o_valid must not glitch high during reset.
- No backpressure on the output; the sink must accept every o_valid.

Test Plan:
- Reset release, no chips: lfsr i_valid high exactly SPREAD cycles, o_ready rises at cycle SPREAD+1, code matches the golden lfsr sequence.
- Spreader loopback, bits 1,0,1,1 with continuous chips -> o_valid every 24 cycles, o_data 1,0,1,1, o_corr 24,0,24,24, o_tie=0.
- Bit 1 with 11 chips inverted -> o_corr=13, o_data=1. With 12 chips inverted -> o_corr=12, o_tie=1, o_data=0.
- Random i_valid gaps (50% duty) over 8 symbols -> identical o_data sequence, exactly one o_valid per 24 accepted chips.
- i_sync asserted at chip 10 of a symbol -> no o_valid for the aborted symbol; the next o_valid comes 24 accepted chips after the sync chip, with correct data.
- Chips driven during LOAD are ignored. Reset asserted mid-symbol -> outputs at reset values; after reload, decoding is correct from the first synced symbol.

Source files
------------

// File: rtl/lfsr.sv
// rtl/lfsr.sv - 8-bit Fibonacci LFSR chip-code generator shared by spreader and despreader
module lfsr #(
    parameter logic [7:0] SEED = 8'hB5
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_valid,
    output logic o_data
);
    logic [7:0] r_state;
    logic       w_feedback;

    // Taps 8,6,5,4 give a maximal-length sequence; output is the MSB before each shift.
    assign w_feedback = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];
    assign o_data     = r_state[7];

    // Advance one step for every cycle the consumer asks for a code bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= SEED;
        end else if (i_valid) begin
            r_state <= {r_state[6:0], w_feedback};
        end
    end
endmodule

// File: rtl/despread.sv
// rtl/despread.sv - chip-stream despreader with majority-vote bit recovery
module despread #(
    parameter int SPREAD       = 24,
    parameter int SIZE_COUNTER = $clog2(SPREAD),
    parameter int CORR_W       = $clog2(SPREAD + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_data,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic              o_ready,
    output logic              o_data,
    output logic              o_valid,
    output logic [CORR_W-1:0] o_corr,
    output logic              o_tie
);
    typedef enum logic {S_LOAD, S_RUN} state_t;

    localparam logic [SIZE_COUNTER-1:0] LAST_IDX = SIZE_COUNTER'(SPREAD - 1);
    localparam logic [CORR_W-1:0]       HALF     = CORR_W'(SPREAD / 2);
    localparam logic [CORR_W:0]         SPREAD_W = (CORR_W + 1)'(SPREAD);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_lfsr_valid;
    logic                    w_lfsr_data;
    logic [SIZE_COUNTER-1:0] r_load_cnt;
    logic [SPREAD-1:0]       r_code;

    logic [SIZE_COUNTER-1:0] r_idx;
    logic [SIZE_COUNTER-1:0] w_idx;
    logic [CORR_W-1:0]       r_acc;
    logic [CORR_W-1:0]       w_acc_base;
    logic [CORR_W-1:0]       w_total;
    logic                    w_accept;
    logic                    w_x;
    logic                    w_last;

    logic                    r_ready;
    logic                    r_valid;
    logic                    r_data;
    logic [CORR_W-1:0]       r_corr;
    logic                    r_tie;

    lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (w_lfsr_valid),
        .o_data  (w_lfsr_data)
    );

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Pull SPREAD code bits from the LFSR, then run forever until reset.
    always_comb begin
        w_next_state = r_state;
        w_lfsr_valid = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_lfsr_valid = 1'b1;
                if (r_load_cnt == LAST_IDX) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN:   w_next_state = S_RUN;
            default: w_next_state = S_LOAD;
        endcase
    end

    // Capture the code bit 0 first, exactly as the spreader does.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_load_cnt <= '0;
            r_code     <= '0;
        end else if (r_state == S_LOAD) begin
            r_code[r_load_cnt] <= w_lfsr_data;
            r_load_cnt         <= r_load_cnt + 1'b1;
        end
    end

    // Ready follows the FSM by one cycle so it is glitch-free at the port.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (r_state == S_RUN);
        end
    end

    // A sync chip restarts the symbol: index and partial count are treated as zero.
    assign w_accept   = i_valid & r_ready;
    assign w_idx      = i_sync ? '0 : r_idx;
    assign w_acc_base = i_sync ? '0 : r_acc;
    assign w_x        = i_data ^ r_code[w_idx];
    assign w_total    = w_acc_base + CORR_W'(w_x);
    assign w_last     = (w_idx == LAST_IDX);

    // Per-chip correlation; the accumulator clears at the symbol boundary.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_idx <= '0;
                r_acc <= '0;
            end else begin
                r_idx <= w_idx + 1'b1;
                r_acc <= w_total;
            end
        end
    end

    // Majority decision on the final chip; results hold until the next symbol.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_data  <= 1'b0;
            r_corr  <= '0;
            r_tie   <= 1'b0;
        end else begin
            r_valid <= w_accept & w_last;
            if (w_accept && w_last) begin
                r_data <= (w_total > HALF);
                r_corr <= w_total;
                r_tie  <= ({w_total, 1'b0} == SPREAD_W);
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_corr  = r_corr;
    assign o_tie   = r_tie;
endmodule
